store_merge_unit: RTL

//   Sequential store path between the LSU and a synchronous word-wide data RAM.

---
 rtl/store_merge_unit_if.sv | 29 ++
 rtl/store_merge_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/store_merge_unit_if.sv
// Store-path bundle: LSU request handshake plus the word-wide RAM port.
// The unit uses the slave view; the LSU/RAM side uses the master view.
interface store_merge_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [31:0]           req_data_i;
  logic [1:0]            req_type_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_re_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  done_o;
  logic                  err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_type_i, mem_rdata_i,
    output req_ready_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o, done_o, err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_type_i, mem_rdata_i,
    input  req_ready_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o, done_o, err_o
  );
endinterface

// File: rtl/store_merge_unit.sv
// Merges byte/half/word stores into RAM words with a registered read-modify-write;
// stores crossing a word boundary are split into two passes (word A, then word B).
module store_merge_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic              clk_i,
  input logic              rst_ni,
  store_merge_unit_if.slave bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int LW   = 2 * NB;
  localparam int SW   = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, ERR} state_t;

  state_t                state_q, state_d;
  logic                  second_q, second_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]         lanes_q, lanes_d;
  logic [SW-1:0]         shifted_q, shifted_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [OFFW-1:0]       cap_off;
  logic [LW-1:0]         cap_mask, cap_lanes;
  logic [SW-1:0]         cap_shifted;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_span, cap_full;

  always_comb begin
    cap_off = bus.req_addr_i[OFFW-1:0];
    case (bus.req_type_i)
      2'b01:   cap_mask = LW'(1);
      2'b10:   cap_mask = LW'(3);
      default: cap_mask = LW'(15);
    endcase
    cap_lanes   = cap_mask << cap_off;
    cap_shifted = SW'(bus.req_data_i) << {cap_off, 3'b000};
    cap_addr    = bus.req_addr_i & ~ADDR_WIDTH'(NB - 1);
    cap_span    = |cap_lanes[LW-1:NB];
    cap_full    = &cap_lanes[NB-1:0];
  end

  // Word B address wraps naturally in ADDR_WIDTH bits.
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [NB-1:0]         cur_lanes;
  logic [DATA_WIDTH-1:0] cur_data, merged;
  logic                  span_q, b_full;

  assign cur_addr  = second_q ? addr_q + ADDR_WIDTH'(NB) : addr_q;
  assign cur_lanes = second_q ? lanes_q[LW-1:NB] : lanes_q[NB-1:0];
  assign cur_data  = second_q ? shifted_q[SW-1:DATA_WIDTH] : shifted_q[DATA_WIDTH-1:0];
  assign span_q    = |lanes_q[LW-1:NB];
  assign b_full    = &lanes_q[LW-1:NB];

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign merged[8*gi +: 8] = cur_lanes[gi] ? cur_data[8*gi +: 8] : bus.mem_rdata_i[8*gi +: 8];
  end

  logic                  ready, re, we, done, err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    second_d  = second_q;
    addr_d    = addr_q;
    lanes_d   = lanes_q;
    shifted_d = shifted_q;
    wdata_d   = wdata_q;
    ready     = 1'b0;
    re        = 1'b0;
    we        = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid_i) begin
          addr_d    = cap_addr;
          lanes_d   = cap_lanes;
          shifted_d = cap_shifted;
          second_d  = 1'b0;
          if (cap_span && !ALLOW_MISALIGNED) begin
            state_d = ERR;
          end else if (cap_full) begin
            wdata_d = cap_shifted[DATA_WIDTH-1:0];
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        re       = 1'b1;
        mem_addr = cur_addr;
        state_d  = MRG;
      end
      MRG: begin
        wdata_d = merged;
        state_d = WR;
      end
      WR: begin
        we        = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = wdata_q;
        if (span_q && !second_q) begin
          second_d = 1'b1;
          if (b_full) begin
            wdata_d = shifted_q[SW-1:DATA_WIDTH];
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o = ready;
  assign bus.mem_re_o    = re;
  assign bus.mem_we_o    = we;
  assign bus.done_o      = done;
  assign bus.err_o       = err;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      second_q  <= 1'b0;
      addr_q    <= '0;
      lanes_q   <= '0;
      shifted_q <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      second_q  <= second_d;
      addr_q    <= addr_d;
      lanes_q   <= lanes_d;
      shifted_q <= shifted_d;
      wdata_q   <= wdata_d;
    end
  end
endmodule
